// File: rtl/edge_capture_pkg.sv
// Shared constants and helpers for the per-channel edge capture block.
package edge_capture_pkg;

    // Per-channel mode encoding as {fall, rise}; software splits it into mode_fall/mode_rise.
    localparam logic [1:0] OFF  = 2'b00;
    localparam logic [1:0] RISE = 2'b01;
    localparam logic [1:0] FALL = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // Sum is formed one bit wider than any count so the clamp never sees a wrapped value.
    function automatic logic [63:0] clamp_add(input logic [63:0] count, input logic [63:0] inc,
                                              input int unsigned cnt_w);
        logic [64:0] sum;
        logic [64:0] max_v;
        sum   = {1'b0, count} + {1'b0, inc};
        max_v = (65'd1 << cnt_w) - 65'd1;
        return (sum > max_v) ? max_v[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/edge_capture_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder; feeds the first-capture index.
module prio_enc_lsb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/edge_capture_ctrl.sv
// Per-channel rise/fall edge capture with sticky status, W1C, overflow, masked irq,
// saturating event counter and first-capture index.
module edge_capture_ctrl
    import edge_capture_pkg::*;
#(
    parameter int unsigned  WIDTH       = 32,
    parameter int unsigned  SYNC_STAGES = 0,
    parameter int unsigned  CNT_W       = 16,
    localparam int unsigned IDX_W       = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] mode_rise,
    input  logic [WIDTH-1:0] mode_fall,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] mask,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] ovf,
    output logic             irq,
    output logic [CNT_W-1:0] evt_count,
    output logic             first_valid,
    output logic [IDX_W-1:0] first_idx
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] in_hist_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] base;
    logic [IDX_W-1:0] det_idx;
    logic             det_any;
    logic [CNT_W-1:0] cnt_base;

    logic [WIDTH-1:0] out_d, out_q;
    logic [WIDTH-1:0] ovf_d, ovf_q;
    logic             irq_d, irq_q;
    logic [CNT_W-1:0] evt_count_d, evt_count_q;
    logic             first_valid_d, first_valid_q;
    logic [IDX_W-1:0] first_idx_d, first_idx_q;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = in;
    end else begin : g_sync
        // Plain shift register, deliberately without reset.
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk) begin
            sync_q[0] <= in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
        assign s = sync_q[SYNC_STAGES-1];
    end

    prio_enc_lsb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec_i (det),
        .idx_o (det_idx),
        .any_o (det_any)
    );

    always_comb begin
        det   = (mode_rise & s & ~in_hist_q) | (mode_fall & ~s & in_hist_q);
        base  = out_q & ~clr;
        out_d = base | det;
        ovf_d = (ovf_q & ~clr) | (det & base);
        irq_d = |(out_q & ~mask);

        cnt_base    = cnt_clr ? '0 : evt_count_q;
        evt_count_d = CNT_W'(clamp_add(64'(cnt_base), 64'(popcount(det)), CNT_W));

        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        // Index is only latched when status goes from all-clear to non-zero.
        if (base == '0) begin
            if (det_any) begin
                first_valid_d = 1'b1;
                first_idx_d   = det_idx;
            end else begin
                first_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // History keeps tracking through reset so release never sees a phantom edge.
        in_hist_q <= s;
        if (reset) begin
            out_q         <= '0;
            ovf_q         <= '0;
            irq_q         <= 1'b0;
            evt_count_q   <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            out_q         <= out_d;
            ovf_q         <= ovf_d;
            irq_q         <= irq_d;
            evt_count_q   <= evt_count_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
        end
    end

    assign out         = out_q;
    assign ovf         = ovf_q;
    assign irq         = irq_q;
    assign evt_count   = evt_count_q;
    assign first_valid = first_valid_q;
    assign first_idx   = first_idx_q;

endmodule

// File: tb/tb_edge_capture_ctrl.sv
// Directed bench for edge_capture_ctrl (WIDTH=32, no synchroniser, 4-bit counter).
module tb_edge_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in, mode_rise, mode_fall, clr, mask;
    logic        cnt_clr;
    logic [31:0] out, ovf;
    logic        irq;
    logic [3:0]  evt_count;
    logic        first_valid;
    logic [4:0]  first_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_capture_ctrl #(
        .WIDTH       (32),
        .SYNC_STAGES (0),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .mode_rise   (mode_rise),
        .mode_fall   (mode_fall),
        .clr         (clr),
        .mask        (mask),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .ovf         (ovf),
        .irq         (irq),
        .evt_count   (evt_count),
        .first_valid (first_valid),
        .first_idx   (first_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in = '0; mode_rise = '0; mode_fall = '0;
        clr = '0; mask = '0; cnt_clr = 1'b0;
        step(); step();
        n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL rst_out got %h want 0", out); end
        n_checks++; if (ovf !== 32'h0) begin n_fail++; $display("FAIL rst_ovf got %h want 0", ovf); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
        n_checks++;
        if (evt_count !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", evt_count); end
        n_checks++;
        if (first_valid !== 1'b0 || first_idx !== 5'd0) begin
            n_fail++; $display("FAIL rst_first got %b/%0d want 0/0", first_valid, first_idx);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_legacy();
        mode_fall = '1; mode_rise = '0;
        in = 32'hFFFF_0000; step();
        n_checks++;
        if (out !== 32'h0) begin n_fail++; $display("FAIL leg_rise got %h want 0", out); end
        in = 32'h0000_FFFF; step();
        n_checks++;
        if (out !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL leg_out got %h want ffff0000", out);
        end
        n_checks++;
        if (first_valid !== 1'b1 || first_idx !== 5'd16) begin
            n_fail++; $display("FAIL leg_first got %b/%0d want 1/16", first_valid, first_idx);
        end
        n_checks++;
        if (evt_count !== 4'd15) begin n_fail++; $display("FAIL leg_cnt got %0d want 15", evt_count); end
        in = 32'hFFFF_FFFF; step();
        n_checks++;
        if (out !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL leg_hold got %h want ffff0000", out);
        end
        in = 32'h0; step();
        n_checks++;
        if (out !== 32'hFFFF_FFFF || ovf !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL leg_ovf got %h/%h want ffffffff/ffff0000", out, ovf);
        end
        n_checks++;
        if (first_idx !== 5'd16) begin n_fail++; $display("FAIL leg_idx got %0d want 16", first_idx); end
        mode_fall = '0; clr = '1; step();
        n_checks++;
        if (out !== 32'h0 || ovf !== 32'h0 || first_valid !== 1'b0) begin
            n_fail++; $display("FAIL leg_clr got %h/%h/%b want 0/0/0", out, ovf, first_valid);
        end
        clr = '0;
    endtask

    task automatic test_both_disabled();
        mode_rise = 32'h1; mode_fall = 32'h3;
        in = 32'h1; step();
        n_checks++;
        if (out !== 32'h1 || ovf !== 32'h0) begin
            n_fail++; $display("FAIL both_first got %h/%h want 1/0", out, ovf);
        end
        in = 32'h0; step();
        n_checks++;
        if (out !== 32'h1 || ovf !== 32'h1) begin
            n_fail++; $display("FAIL both_second got %h/%h want 1/1", out, ovf);
        end
        in = 32'h4; step(); in = 32'h0; step();
        n_checks++;
        if (out !== 32'h1) begin n_fail++; $display("FAIL off_bit2 got %h want 1", out); end
        // Mode enabled while the line is already high must not produce an edge.
        in = 32'h10; step(); mode_rise = 32'h11; step();
        n_checks++;
        if (out !== 32'h1) begin n_fail++; $display("FAIL mode_toggle got %h want 1", out); end
        mode_rise = '0; mode_fall = '0; in = '0; clr = '1; step();
        clr = '0;
    endtask

    task automatic test_w1c_race();
        mode_rise = 32'h20; mode_fall = 32'h20;
        in = 32'h20; step();
        n_checks++;
        if (out !== 32'h20) begin n_fail++; $display("FAIL w1c_set got %h want 20", out); end
        in = 32'h0; clr = 32'h20; step();
        n_checks++;
        if (out !== 32'h20 || ovf !== 32'h0) begin
            n_fail++; $display("FAIL w1c_race got %h/%h want 20/0", out, ovf);
        end
        step();
        n_checks++;
        if (out !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got %h want 0", out); end
        clr = '0; mode_rise = '0; mode_fall = '0;
    endtask

    task automatic test_irq_mask();
        mode_rise = 32'h100; mask = 32'h100;
        in = 32'h100; step(); step();
        n_checks++;
        if (out !== 32'h100 || irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked got %h/%b want 100/0", out, irq);
        end
        mask = '0; step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask got %b want 1", irq); end
        clr = 32'h100; step();
        n_checks++;
        if (out !== 32'h0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_lag got %h/%b want 0/1", out, irq);
        end
        step();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
        clr = '0; mode_rise = '0; in = '0; step();
    endtask

    task automatic test_counter_sat();
        logic [3:0] exp_cnt [4];
        exp_cnt[0] = 4'd5; exp_cnt[1] = 4'd10; exp_cnt[2] = 4'd15; exp_cnt[3] = 4'd15;
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        n_checks++;
        if (evt_count !== 4'd0) begin n_fail++; $display("FAIL cnt_zero got %0d want 0", evt_count); end
        mode_rise = 32'h1F; mode_fall = 32'h1F;
        for (int k = 0; k < 4; k++) begin
            in = (k % 2 == 0) ? 32'h1F : 32'h0;
            step();
            n_checks++;
            if (evt_count !== exp_cnt[k]) begin
                n_fail++; $display("FAIL cnt_sat%0d got %0d want %0d", k, evt_count, exp_cnt[k]);
            end
        end
        mode_rise = 32'h3; mode_fall = 32'h3; in = 32'h3; cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        n_checks++;
        if (evt_count !== 4'd2) begin n_fail++; $display("FAIL cnt_clr2 got %0d want 2", evt_count); end
        mode_rise = '0; mode_fall = '0; in = '0; clr = '1; step();
        clr = '0;
    endtask

    task automatic test_first_idx();
        mode_rise = '1;
        in = 32'h88; step();
        n_checks++;
        if (first_valid !== 1'b1 || first_idx !== 5'd3) begin
            n_fail++; $display("FAIL first_set got %b/%0d want 1/3", first_valid, first_idx);
        end
        in = 32'h8A; step();
        n_checks++;
        if (out !== 32'h8A || first_idx !== 5'd3) begin
            n_fail++; $display("FAIL first_hold got %h/%0d want 8a/3", out, first_idx);
        end
        clr = '1; step(); clr = '0;
        n_checks++;
        if (first_valid !== 1'b0 || first_idx !== 5'd3) begin
            n_fail++; $display("FAIL first_clr got %b/%0d want 0/3", first_valid, first_idx);
        end
    endtask

    task automatic test_reset_midcapture();
        mode_rise = '1; mode_fall = '1;
        reset = 1'b1; in = 32'h0F; step();
        in = 32'hF0; step();
        n_checks++;
        if (out !== 32'h0 || ovf !== 32'h0 || irq !== 1'b0 || evt_count !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid got %h/%h/%b/%0d want 0/0/0/0", out, ovf, irq, evt_count);
        end
        reset = 1'b0; step();
        n_checks++;
        if (out !== 32'h0 || evt_count !== 4'd0 || first_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_phantom got %h/%0d/%b want 0/0/0", out, evt_count, first_valid);
        end
        in = 32'hF1; step();
        n_checks++;
        if (out !== 32'h1 || first_valid !== 1'b1 || first_idx !== 5'd0 || evt_count !== 4'd1) begin
            n_fail++;
            $display("FAIL rst_after got %h/%b/%0d/%0d want 1/1/0/1", out, first_valid, first_idx,
                     evt_count);
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_both_disabled();
        test_w1c_race();
        test_irq_mask();
        test_counter_sat();
        test_first_idx();
        test_reset_midcapture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_capture_ctrl.md
Name: edge_capture_ctrl

Overview:
- Parametrised successor to the fixed 32-bit falling-edge capture block.
- Each channel has its own edge mode: rising, falling, both or disabled. Captures are sticky.
- Adds per-bit write-1-to-clear, overflow flags, a masked interrupt, a saturating event counter and a first-capture index.
- Sits between raw status/event lines and the CSR/interrupt logic.

Parameters:
- WIDTH, 32, number of channels (1..64).
- SYNC_STAGES, 0, input synchroniser flops per bit (0..3); 0 means the input is already in the clk domain.
- CNT_W, 16, event counter width (>= clog2(WIDTH+1)).
- IDX_W, derived localparam = max(1, clog2(WIDTH)), width of the channel index.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous, active-high.
- in, input, WIDTH, monitored lines.
- mode_rise, input, WIDTH, per-bit enable for 0->1 capture.
- mode_fall, input, WIDTH, per-bit enable for 1->0 capture (all-ones reproduces the legacy block).
- clr, input, WIDTH, write-1-to-clear of out/ovf bits, sampled every cycle.
- mask, input, WIDTH, 1 = channel excluded from irq.
- cnt_clr, input, 1, clears evt_count.
- out, output, WIDTH, sticky capture status.
- ovf, output, WIDTH, sticky "edge while already captured".
- irq, output, 1, = |(out & ~mask), driven only from flops.
- evt_count, output, CNT_W, saturating count of detected edges.
- first_valid, output, 1, first_idx holds a valid index.
- first_idx, output, IDX_W, lowest channel captured when status went from all-clear to non-zero.

Behaviour:
- Synchroniser: s = in delayed by SYNC_STAGES flops (s = in when 0). Synchroniser flops are not reset.
- History: in_d <= s every cycle, including during reset and with no reset value. At reset release, only real transitions relative to the last sampled value are captured.
- Detect (combinational): det = (mode_rise & s & ~in_d) | (mode_fall & ~s & in_d).
- Latency, SYNC_STAGES=0: in changes before edge k → det high in the cycle ending at edge k → out bit high after edge k. Each sync stage adds one cycle.
- Status update: out <= (out & ~clr) | det.
  - det wins over clr in the same cycle; the edge is never lost.
  - A bit with both mode_* = 0 never sets, but can still be cleared.
- Overflow: ovf <= (ovf & ~clr) | (det & out & ~clr). The bit already set and not being cleared gets a new edge → ovf set.
- Counter: evt_count <= cnt_clr ? min(popcount(det), MAX) : min(evt_count + popcount(det), MAX), where MAX = 2^CNT_W-1.
  - Compute the sum one bit wider, then clamp.
  - Holds at MAX with no wrap.
- First capture: base = out & ~clr.
  - base==0 and det!=0 → first_idx <= lowest set index of det, first_valid <= 1.
  - base==0 and det==0 → first_valid <= 0, first_idx holds.
  - otherwise both hold.
- Reset (sync, overrides everything else): out=0, ovf=0, evt_count=0, first_valid=0, first_idx=0; irq follows as 0 next cycle. in_d keeps tracking, so reset mid-capture discards status but no phantom edge appears after release.
- Mode changes take effect the same cycle. Toggling a mode never creates an edge by itself.

Decomposition:
- Package edge_capture_pkg holds:
  - the mode encoding constants (RISE, FALL, BOTH, OFF) for software/bench use;
  - a function clamp_add(count, inc, CNT_W);
  - a clog2 helper.
- One sub-module: prio_enc_lsb (parameter WIDTH; outputs index of lowest set bit plus any-set). Used for first_idx.
- Popcount stays inline as a function.

Test Plan:
- Legacy mode: WIDTH=32, mode_fall=all 1s, mode_rise=0. Drive in 0xFFFF0000→0x0000FFFF → out=0xFFFF0000 one cycle later. Subsequent in changes do not drop bits.
- Both-edge and disabled: mode_rise=0x1, mode_fall=0x3, bit0 toggles 0→1→0 → out[0] sets on the first edge and ovf[0] on the second. bit2 (mode off) toggling leaves out[2]=0.
- W1C race: out[5]=1, then clr=0x20 in the same cycle as a new edge on bit5 → out[5] stays 1 and ovf[5] stays 0. clr=0x20 with no edge → out[5]=0 next cycle.
- irq/mask: out=0x0100 with mask=0x0100 → irq=0. Drop mask → irq=1 next cycle. Clear bit8 → irq=0.
- Counter saturation: CNT_W=4, 5 edges/cycle for 4 cycles → 5, 10, 15, 15. cnt_clr together with 2 edges → 2.
- First index and reset: all-clear, simultaneous edges on bits 7 and 3 → first_idx=3, first_valid=1. A later edge on bit 1 leaves it at 3. Clearing all → first_valid=0. Assert reset for 2 cycles while in toggles → all outputs 0, and no capture at release unless in transitions after release.
